// File: rtl/operand_entry_pkg.sv
// Shared types for the operand entry controller: state encoding and its width.
package operand_entry_pkg;

    localparam int STATE_W = 3;

    // Encoding 7 is deliberately left unused; the FSM recovers from it to ST_LOAD_AR.
    typedef enum logic [STATE_W-1:0] {
        ST_LOAD_AR = 3'd0,
        ST_LOAD_AI = 3'd1,
        ST_LOAD_BR = 3'd2,
        ST_LOAD_BI = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_SHOW    = 3'd6
    } state_t;

endpackage : operand_entry_pkg

// File: rtl/operand_entry_ctrl_rise_detect.sv
// Rising-edge detector for one debounced button. The history register resets
// to 1 so that a button held down through reset does not produce a press.
module rise_detect (
    input  logic clk,
    input  logic n_reset,
    input  logic i_btn,
    output logic o_press
);

    logic r_prev;

    // Track the button level from the previous cycle.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_press = i_btn & ~r_prev;

endmodule : rise_detect

// File: rtl/operand_entry_ctrl.sv
// Operand entry controller: walks the user through entering A and B from the
// switches, launches the complex multiplier through a start/ready handshake,
// waits for its done pulse (or a timeout) and then holds the result display.
//
// Handshake: mult_start is a registered request raised one cycle after entering
// START and held until a cycle where mult_start and mult_ready are both high;
// that cycle is the single transfer, after which mult_start drops and the FSM
// moves to WAIT. mult_done is a one-cycle pulse that is only honoured in WAIT.
module operand_entry_ctrl
    import operand_entry_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               btn_next,
    input  logic               btn_back,
    input  logic [WIDTH-1:0]   sw,
    input  logic               mult_ready,
    input  logic               mult_done,
    output logic [WIDTH-1:0]   a_re,
    output logic [WIDTH-1:0]   a_im,
    output logic [WIDTH-1:0]   b_re,
    output logic [WIDTH-1:0]   b_im,
    output logic               mult_start,
    output logic [STATE_W-1:0] state_idx,
    output logic               show_result,
    output logic               err
);

    // Wait counter runs 0..TIMEOUT-1 while in WAIT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_re;
    logic [WIDTH-1:0] r_a_im;
    logic [WIDTH-1:0] r_b_re;
    logic [WIDTH-1:0] r_b_im;
    logic             r_mult_start;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic w_next_raw;
    logic w_back_raw;
    logic w_next_p;
    logic w_back_p;
    logic w_xfer;
    logic w_timeout;
    logic w_err_clr;

    rise_detect u_next_det (
        .clk     (clk),
        .n_reset (n_reset),
        .i_btn   (btn_next),
        .o_press (w_next_raw)
    );

    rise_detect u_back_det (
        .clk     (clk),
        .n_reset (n_reset),
        .i_btn   (btn_back),
        .o_press (w_back_raw)
    );

    // Simultaneous next and back presses cancel each other out.
    assign w_next_p = w_next_raw & ~w_back_raw;
    assign w_back_p = w_back_raw & ~w_next_raw;

    assign w_xfer    = (r_state == ST_START) & r_mult_start & mult_ready;
    // Done has priority over the timeout on the same cycle.
    assign w_timeout = (r_state == ST_WAIT) & ~mult_done & (r_cnt == CNT_LAST);
    assign w_err_clr = (r_state == ST_SHOW) & w_next_p;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD_AR: begin
                if (w_next_p) w_state_nxt = ST_LOAD_AI;
            end
            ST_LOAD_AI: begin
                if (w_next_p)      w_state_nxt = ST_LOAD_BR;
                else if (w_back_p) w_state_nxt = ST_LOAD_AR;
            end
            ST_LOAD_BR: begin
                if (w_next_p)      w_state_nxt = ST_LOAD_BI;
                else if (w_back_p) w_state_nxt = ST_LOAD_AI;
            end
            ST_LOAD_BI: begin
                if (w_next_p)      w_state_nxt = ST_START;
                else if (w_back_p) w_state_nxt = ST_LOAD_BR;
            end
            ST_START: begin
                if (w_xfer) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_done || w_timeout) w_state_nxt = ST_SHOW;
            end
            ST_SHOW: begin
                if (w_next_p)      w_state_nxt = ST_LOAD_AR;
                else if (w_back_p) w_state_nxt = ST_LOAD_BI;
            end
            default: begin
                w_state_nxt = ST_LOAD_AR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state <= ST_LOAD_AR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand registers: copy sw on a next press in the matching LOAD state.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_a_re <= '0;
            r_a_im <= '0;
            r_b_re <= '0;
            r_b_im <= '0;
        end else if (w_next_p) begin
            case (r_state)
                ST_LOAD_AR: r_a_re <= sw;
                ST_LOAD_AI: r_a_im <= sw;
                ST_LOAD_BR: r_b_re <= sw;
                ST_LOAD_BI: r_b_im <= sw;
                default:    ;
            endcase
        end
    end

    // Start request: raised the cycle after entering START, dropped after transfer.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_mult_start <= 1'b0;
        end else if (w_xfer) begin
            r_mult_start <= 1'b0;
        end else begin
            r_mult_start <= (r_state == ST_START);
        end
    end

    // Wait counter: zero outside WAIT, counts up each cycle inside it.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared when the user leaves SHOW for LOAD_AR.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign a_re        = r_a_re;
    assign a_im        = r_a_im;
    assign b_re        = r_b_re;
    assign b_im        = r_b_im;
    assign mult_start  = r_mult_start;
    assign state_idx   = r_state;
    assign show_result = (r_state == ST_SHOW);
    assign err         = r_err;

endmodule : operand_entry_ctrl
